// File: rtl/board_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_pattern_gen_if
//  Description : Request/status bundle for board_pattern_gen. The requester
//                (master) drives the start request and pattern controls; the
//                generator (slave) returns the bitmap and status flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface board_pattern_gen_if #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
);
    logic                       start;
    logic [2:0]                 mode;
    logic [5:0]                 row_count;
    logic [15:0]                seed;
    logic [BOARD_W*BOARD_H-1:0] board;
    logic                       busy;
    logic                       done;
    logic                       board_valid;

    modport master (
        output start, mode, row_count, seed,
        input  board, busy, done, board_valid
    );

    modport slave (
        input  start, mode, row_count, seed,
        output board, busy, done, board_valid
    );
endinterface
`default_nettype wire

// File: rtl/board_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : board_pattern_gen
//  Description : Generates a start-of-game board bitmap one row per cycle.
//                Patterns: CLEAR, BOTTOM_FILL, CHECKER and (optionally)
//                GARBAGE driven by a 16-bit Galois LFSR.
//                Define BOARD_PATTERN_GARBAGE_EN to build the GARBAGE mode
//                and its LFSR; otherwise mode 3 produces a clear board.
//  Revision    : 1.0  initial release
// ============================================================================
module board_pattern_gen #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  wire logic           clk,
    input  wire logic           rst,
    board_pattern_gen_if.slave  bus
);

    localparam int ROW_W = $clog2(BOARD_H);
    localparam int COL_W = $clog2(BOARD_W);

    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(BOARD_H - 1);
    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(BOARD_W - 1);
    localparam logic [5:0]       C_MAX_ROWS = 6'(BOARD_H);
`ifdef BOARD_PATTERN_GARBAGE_EN
    localparam logic [15:0]      C_LFSR_DEFAULT = 16'hACE1;
    localparam logic [15:0]      C_LFSR_MASK    = 16'hB400;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PAT_CLEAR   = 2'd0,
        PAT_BOTTOM  = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_GARBAGE = 2'd3
    } pattern_t;

    state_t                     r_state;
    pattern_t                   r_pat;
    logic [5:0]                 r_cnt;
    logic [ROW_W-1:0]           r_row;
    logic [COL_W-1:0]           r_hole;
    logic [BOARD_W*BOARD_H-1:0] r_board;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_valid;
`ifdef BOARD_PATTERN_GARBAGE_EN
    logic [15:0]                r_lfsr;
`endif

    pattern_t                   w_pat_in;
    logic [5:0]                 w_cnt_in;
    logic                       w_in_range;
    logic [BOARD_W-1:0]         w_row;

    // Decode the requested mode into a pattern; unused codes fall back to CLEAR
    always_comb begin
        w_pat_in = PAT_CLEAR;
        case (bus.mode)
            3'd1:    w_pat_in = PAT_BOTTOM;
            3'd2:    w_pat_in = PAT_CHECKER;
`ifdef BOARD_PATTERN_GARBAGE_EN
            3'd3:    w_pat_in = PAT_GARBAGE;
`endif
            default: w_pat_in = PAT_CLEAR;
        endcase
        w_cnt_in = (bus.row_count > C_MAX_ROWS) ? C_MAX_ROWS : bus.row_count;
    end

    // Content of the row currently addressed by the row pointer
    always_comb begin
        // r >= H - cnt, rearranged to avoid an unsigned underflow
        w_in_range = (int'(r_row) + int'(r_cnt)) >= BOARD_H;
        w_row      = '0;
        for (int c = 0; c < BOARD_W; c++) begin
            case (r_pat)
                PAT_BOTTOM:  w_row[c] = w_in_range && (c != int'(r_hole));
                PAT_CHECKER: w_row[c] = r_row[0] ^ c[0];
`ifdef BOARD_PATTERN_GARBAGE_EN
                PAT_GARBAGE: w_row[c] = w_in_range && (c != int'(r_hole)) && r_lfsr[c];
`endif
                default:     w_row[c] = 1'b0;
            endcase
        end
    end

    // Control FSM, row writer, hole-column tracker and LFSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pat   <= PAT_CLEAR;
            r_cnt   <= '0;
            r_row   <= '0;
            r_hole  <= '0;
            r_board <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
`ifdef BOARD_PATTERN_GARBAGE_EN
            r_lfsr  <= C_LFSR_DEFAULT;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_pat   <= w_pat_in;
                        r_cnt   <= w_cnt_in;
                        r_row   <= '0;
                        r_hole  <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
`ifdef BOARD_PATTERN_GARBAGE_EN
                        r_lfsr  <= (bus.seed == 16'h0000) ? C_LFSR_DEFAULT : bus.seed;
`endif
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_board[int'(r_row)*BOARD_W +: BOARD_W] <= w_row;
                    // Hole column is row mod width, kept as a wrapping counter
                    r_hole <= (r_hole == C_LAST_COL) ? '0 : r_hole + COL_W'(1);
`ifdef BOARD_PATTERN_GARBAGE_EN
                    if ((r_pat == PAT_GARBAGE) && w_in_range) begin
                        r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? C_LFSR_MASK : 16'h0000);
                    end
`endif
                    if (r_row == C_LAST_ROW) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.board       = r_board;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.board_valid = r_valid;

endmodule
`default_nettype wire
